// File: rtl/mapper_hotspot_gen.sv
// Parametrised hotspot bankswitch mapper with optional Superchip-style cart RAM window.
// Define MAPPER_HOTSPOT_DEBOUNCE_EN to require SETTLE_CLKS stable clocks before acting.
module mapper_hotspot_gen #(
    parameter int unsigned NUM_BANKS    = 8,
    parameter logic [12:0] HOTSPOT_BASE = 13'h1FF4,
    parameter int unsigned RAM_BYTES    = 128,
    parameter int unsigned SETTLE_CLKS  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi1,
    input  logic        sc,
    input  logic [12:0] a_in,
    input  logic [7:0]  d_in,
    input  logic [7:0]  rom_do,
    input  logic [7:0]  ram_do,
    output logic [7:0]  d_out,
    output logic [7:0]  oe,
    output logic [18:0] rom_a,
    output logic        rom_read,
    output logic [17:0] ram_a,
    output logic        ram_wr,
    output logic        ram_rd,
    output logic [7:0]  ram_wrdata,
    output logic [5:0]  bank
);

    localparam int unsigned BW    = $clog2(NUM_BANKS);
    localparam logic [13:0] HsLo  = 14'(HOTSPOT_BASE);
    localparam logic [13:0] HsHi  = 14'(32'(HOTSPOT_BASE) + NUM_BANKS - 1);
    localparam logic [13:0] WrLo  = 14'h1000;
    localparam logic [13:0] RdLo  = 14'(32'h1000 + RAM_BYTES);
    localparam logic [13:0] RdEnd = 14'(32'h1000 + 2 * RAM_BYTES);

    if (32'(HOTSPOT_BASE) + NUM_BANKS - 1 > 32'h1FFF) begin : g_chk_hs_top
        $fatal(1, "hotspot range runs past 13'h1FFF");
    end
    if (32'(HOTSPOT_BASE) < 32'h1000 + 2 * RAM_BYTES) begin : g_chk_hs_ram
        $fatal(1, "hotspot range overlaps the cart RAM windows");
    end
    if (NUM_BANKS < 2 || NUM_BANKS > 64 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_chk_nb
        $fatal(1, "NUM_BANKS must be a power of two in 2..64");
    end
    if (RAM_BYTES != 128 && RAM_BYTES != 256) begin : g_chk_ram
        $fatal(1, "RAM_BYTES must be 128 or 256");
    end
    if (SETTLE_CLKS < 1 || SETTLE_CLKS > 15) begin : g_chk_settle
        $fatal(1, "SETTLE_CLKS must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StSettle, StAct, StDone} state_e;

    state_e          state_q, state_d;
    logic [12:0]     old_a_q;
    logic [BW-1:0]   bank_q, bank_d;
`ifdef MAPPER_HOTSPOT_DEBOUNCE_EN
    logic [3:0]      cnt_q, cnt_d;
`endif

    logic [13:0] a14;
    logic        a_chg, in_hs, in_wr, in_rd, wr_hit;

    assign a14    = {1'b0, a_in};
    assign a_chg  = (a_in != old_a_q);
    assign in_hs  = (a14 >= HsLo) && (a14 <= HsHi);
    assign in_wr  = (a14 >= WrLo) && (a14 < RdLo);
    assign in_rd  = (a14 >= RdLo) && (a14 < RdEnd);
    assign wr_hit = sc && in_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_a_q <= 13'd0;
            state_q <= StIdle;
            bank_q  <= BW'(NUM_BANKS - 1);
`ifdef MAPPER_HOTSPOT_DEBOUNCE_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            old_a_q <= a_in;
            state_q <= state_d;
            bank_q  <= bank_d;
`ifdef MAPPER_HOTSPOT_DEBOUNCE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // The bank is latched on the edge that enters ACT, while the settled address is still present.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        ram_wr  = 1'b0;
`ifdef MAPPER_HOTSPOT_DEBOUNCE_EN
        cnt_d   = cnt_q;
`endif
        if (a_chg) begin
            state_d = StSettle;
`ifdef MAPPER_HOTSPOT_DEBOUNCE_EN
            cnt_d   = 4'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StSettle: begin
`ifdef MAPPER_HOTSPOT_DEBOUNCE_EN
                    if (cnt_q == 4'(SETTLE_CLKS - 1)) begin
                        state_d = StAct;
                        if (in_hs) bank_d = BW'(a14 - HsLo);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
`else
                    state_d = StAct;
                    if (in_hs) bank_d = BW'(a14 - HsLo);
`endif
                end
                StAct: begin
                    if (wr_hit && phi1) begin
                        state_d = StAct;
                    end else begin
                        ram_wr  = wr_hit;
                        state_d = StDone;
                    end
                end
                StDone: state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    assign bank       = 6'(bank_q);
    assign rom_a      = {1'b0, 6'(bank_q), a_in[11:0]};
    assign rom_read   = ~a_chg;
    assign ram_rd     = sc && in_rd && !a_chg && !phi1;
    assign ram_a      = 18'(a_in & 13'(RAM_BYTES - 1));
    assign ram_wrdata = d_in;
    assign oe         = !a_in[12] ? 8'h00 : (wr_hit ? 8'h00 : 8'hFF);
    assign d_out      = (sc && in_rd) ? ram_do : (a_in[12] ? rom_do : 8'h00);

endmodule

// File: doc/mapper_hotspot_gen.md
Name: mapper_hotspot_gen

Overview:
Parametrised hotspot bankswitch mapper for the 2600 cartridge slot. It generalises the fixed F8/F6/F4/EF family to a configurable bank count, hotspot base and optional Superchip-style RAM window. Address-change detection and a settle/act state machine are internal, so the block never acts on a transient bus address. It instantiates alongside the existing mappers and presents the same d_out/oe/rom_a/cart-RAM interface as they do.

Parameters:
NUM_BANKS, 8, number of 4 KB ROM banks; power of two, 2..64
HOTSPOT_BASE, 13'h1FF4, address of the bank-0 hotspot; hotspots are HOTSPOT_BASE..HOTSPOT_BASE+NUM_BANKS-1
RAM_BYTES, 128, cart RAM size; legal values 128 or 256; write window $1000+[0,RAM_BYTES), read window follows it
SETTLE_CLKS, 3, clocks the address must be stable before acting; 1..15

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-high reset
phi1  in  1  CPU phase-1; RAM writes are held off while high
sc  in  1  cart RAM enable
a_in  in  13  cart address bus
d_in  in  8  cart data bus (writes)
rom_do  in  8  SDRAM ROM data
ram_do  in  8  cart RAM read data
d_out  out  8  data driven to bus
oe  out  8  output-enable mask
rom_a  out  19  absolute ROM byte address
rom_read  out  1  ROM read request
ram_a  out  18  cart RAM address
ram_wr  out  1  cart RAM write strobe
ram_rd  out  1  cart RAM read strobe
ram_wrdata  out  8  cart RAM write data
bank  out  6  current bank (upper bits zero)

Behaviour:
- Elaboration checks:
  - HOTSPOT_BASE+NUM_BANKS-1 <= 13'h1FFF.
  - HOTSPOT_BASE >= $1000 + 2*RAM_BYTES.
  - NUM_BANKS is a power of two.
  - Any violation is a $fatal.
- Address tracking:
  - old_a register, 13 bits, reset 0.
  - a_chg = (a_in != old_a), combinational.
  - old_a <= a_in every clk.
- FSM states: IDLE, SETTLE, ACT, DONE. Reset state is IDLE; cnt = 0.
  - Any state with a_chg=1 -> SETTLE, cnt <= 0. This has priority over every other transition.
  - SETTLE: cnt increments each stable clk; -> ACT when cnt == SETTLE_CLKS-1.
  - ACT (one clk, or held, see below):
    - If a_in is a hotspot: bank <= a_in - HOTSPOT_BASE, truncated to log2(NUM_BANKS) bits.
    - If sc=1 and a_in is in the write window: ram_wr=1 for exactly this clk, provided phi1=0. If phi1=1, stay in ACT until phi1=0.
    - Then -> DONE.
  - DONE: hold until a_chg.
- Bank register:
  - Reset value NUM_BANKS-1 (last bank).
  - Hotspots act on any access type; there is no R/W pin.
- rom_a = {bank, a_in[11:0]} zero-extended to 19 bits.
- rom_read = ~a_chg.
- RAM signals:
  - ram_rd = sc & a_in in read window & ~a_chg & ~phi1.
  - ram_a = zero-extended offset within the active window, (RAM_BYTES-1) masked.
  - ram_wrdata = d_in.
- oe:
  - 8'hFF when a_in[12]=1, except 8'h00 when sc=1 and a_in is in the write window.
  - 8'h00 when a_in[12]=0.
- d_out:
  - ram_do when sc and a_in is in the read window.
  - Otherwise rom_do when a_in[12].
  - Otherwise 8'h00.
- sc=0: RAM windows read as ROM and ram_wr/ram_rd are never asserted.
- Reset mid-cycle: outputs immediately return to reset values (bank=NUM_BANKS-1, ram_wr=0, state IDLE). No write completes.
- Reset values of all other outputs:
  - rom_read=1, since a_in matches old_a=0 only after the first clk; it is combinational.
  - ram_wr=0, ram_rd=0.
  - All others follow the combinational rules above.
- A hotspot address re-presented after another address triggers again; a re-select of the same bank is harmless.

Optional Feature:
- Macro: MAPPER_HOTSPOT_DEBOUNCE_EN.
- Defined: SETTLE waits the full SETTLE_CLKS stable clocks, as described above.
- Undefined: SETTLE_CLKS is ignored and SETTLE -> ACT on the first stable clk, so the action happens 1 clk after the change. This gives lower latency for glitch-free buses.
- All other behaviour is identical.

Test Plan:
- Reset, NUM_BANKS=8, HOTSPOT_BASE=$1FF4: bank=7, read $1000 -> rom_a=19'h07000, oe=8'hFF.
- Hold a_in=$1FF6 for 4 clks (debounce on, SETTLE_CLKS=3) -> bank=2 after the 4th clk; next read at $1123 -> rom_a=19'h02123.
- Glitch: a_in=$1FF9 for 2 clks, then $1200 -> bank unchanged (7); with macro undefined -> bank=5.
- sc=1, write $1005 with d_in=$A5 and phi1 held high for 3 clks after settle -> ram_wr is a single pulse after phi1 falls, ram_a=5, oe=8'h00. Then read $1085 -> ram_rd=1, d_out=ram_do.
- sc=0, read $1085 -> d_out=rom_do, ram_rd=0, ram_wr never asserted during $1005 access.
- Assert reset during ACT on $1005 with phi1=1 -> ram_wr stays 0, bank=7, state IDLE. Release, re-access $1FF4 -> bank=0.
